scan_test_controller: RTL and testbench

Sequencer for serial-scan exhaustive testing of the CUT. It applies every input pattern 0 … 2^N_IN−1 through a scan-in chain and pulses capture. It then shifts the CUT response out serially and compares it against a golden expected response, accumulating pass/fail results. It sits between the test bench or tester and a scan wrapper around the CUT, replacing the free-running pattern counter used for functional testing.

---
 rtl/scan_test_controller_pkg.sv | 25 ++
 rtl/scan_test_controller_if.sv | 36 +++
 rtl/scan_test_controller.sv | 132 +++++++++++++
 tb/tb_scan_test_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_test_controller_pkg.sv
// Shared constants and state encoding for the serial-scan exhaustive test controller.
package scan_ctrl_pkg;

  localparam int unsigned DEF_N_IN    = 4;
  localparam int unsigned DEF_N_OUT   = 2;
  localparam int unsigned NUM_PAT     = 1 << DEF_N_IN;
  localparam int unsigned CYC_PER_PAT = DEF_N_IN + DEF_N_OUT + 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_SHIFT_IN  = 3'd1;
  localparam state_t S_CAPTURE   = 3'd2;
  localparam state_t S_SHIFT_OUT = 3'd3;
  localparam state_t S_COMPARE   = 3'd4;
  localparam state_t S_DONE      = 3'd5;

  // Bit counter width shared by both shift phases; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/scan_test_controller_if.sv
// Bundle between the controller, the scan wrapper around the CUT and the tester.
interface scan_test_controller_if
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned N_OUT = DEF_N_OUT
);

  logic             start;
  logic             abort;
  logic             scan_in;
  logic             shift_in_en;
  logic             capture;
  logic             shift_out_en;
  logic             scan_out;
  logic [N_IN-1:0]  pat_idx;
  logic [N_OUT-1:0] exp_resp;
  logic             busy;
  logic             done;
  logic [N_IN:0]    fail_count;
  logic             fail_any;
  logic [N_IN-1:0]  first_fail;

  modport master (
    input  start, abort, scan_out, exp_resp,
    output scan_in, shift_in_en, capture, shift_out_en, pat_idx,
           busy, done, fail_count, fail_any, first_fail
  );

  modport slave (
    output start, abort, scan_out, exp_resp,
    input  scan_in, shift_in_en, capture, shift_out_en, pat_idx,
           busy, done, fail_count, fail_any, first_fail
  );

endinterface

// File: rtl/scan_test_controller.sv
// Walks every input pattern through the scan chain, captures, shifts the response out
// and tallies mismatches against the golden response.
module scan_test_controller
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned N_OUT = DEF_N_OUT
) (
  input logic                   clk,
  input logic                   rst,
  scan_test_controller_if.master bus
);

  localparam int unsigned     CW       = cnt_width(N_IN, N_OUT);
  localparam logic [N_IN-1:0] LAST_PAT = '1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]  pat_q, pat_d, pat_shl;
  logic [N_OUT-1:0] resp_q, resp_d;
  logic [N_IN:0]    fcnt_q, fcnt_d;
  logic             fany_q, fany_d;
  logic [N_IN-1:0]  ffirst_q, ffirst_d;
  logic             scan_in_q, shift_in_en_q, capture_q, shift_out_en_q, busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    resp_d   = resp_q;
    fcnt_d   = fcnt_q;
    fany_d   = fany_q;
    ffirst_d = ffirst_q;
    if (bus.abort) begin
      // Abort freezes every result and index; it only returns the FSM to idle.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            fcnt_d   = '0;
            fany_d   = 1'b0;
            ffirst_d = '0;
            pat_d    = '0;
            cnt_d    = '0;
            state_d  = S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          if (cnt_q == CW'(N_IN - 1)) begin
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CAPTURE: state_d = S_SHIFT_OUT;
        S_SHIFT_OUT: begin
          resp_d = N_OUT'({resp_q, bus.scan_out});
          if (cnt_q == CW'(N_OUT - 1)) begin
            cnt_d   = '0;
            state_d = S_COMPARE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_COMPARE: begin
          if (resp_q != bus.exp_resp) begin
            fcnt_d = fcnt_q + (N_IN + 1)'(1);
            fany_d = 1'b1;
            if (!fany_q) ffirst_d = pat_q;
          end
          if (pat_q == LAST_PAT) begin
            state_d = S_DONE;
          end else begin
            pat_d   = pat_q + N_IN'(1);
            state_d = S_SHIFT_IN;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next scan bit is the MSB of the next pattern after dropping the bits already sent.
  assign pat_shl = pat_d << cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pat_q          <= '0;
      resp_q         <= '0;
      fcnt_q         <= '0;
      fany_q         <= 1'b0;
      ffirst_q       <= '0;
      scan_in_q      <= 1'b0;
      shift_in_en_q  <= 1'b0;
      capture_q      <= 1'b0;
      shift_out_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pat_q          <= pat_d;
      resp_q         <= resp_d;
      fcnt_q         <= fcnt_d;
      fany_q         <= fany_d;
      ffirst_q       <= ffirst_d;
      scan_in_q      <= (state_d == S_SHIFT_IN) && pat_shl[N_IN-1];
      shift_in_en_q  <= (state_d == S_SHIFT_IN);
      capture_q      <= (state_d == S_CAPTURE);
      shift_out_en_q <= (state_d == S_SHIFT_OUT);
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
    end
  end

  assign bus.scan_in      = scan_in_q;
  assign bus.shift_in_en  = shift_in_en_q;
  assign bus.capture      = capture_q;
  assign bus.shift_out_en = shift_out_en_q;
  assign bus.pat_idx      = pat_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail_count   = fcnt_q;
  assign bus.fail_any     = fany_q;
  assign bus.first_fail   = ffirst_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Scoreboard bench: behavioural scan wrapper + CUT, golden table with injectable corruption.
module tb_scan_test_controller;

  localparam int NI      = 4;
  localparam int NO      = 2;
  localparam int NPAT    = 1 << NI;
  localparam int RUN_CYC = NPAT * (NI + NO + 2) + 1;

  typedef struct {
    int fc;
    int fany;
    int ff;
    int start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  logic [NI-1:0] in_chain  = '0;
  logic [NO-1:0] out_chain = '0;
  logic [NO-1:0] corrupt [NPAT];

  scan_test_controller_if #(.N_IN(NI), .N_OUT(NO)) bus ();

  scan_test_controller #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NO-1:0] cut_fn(input logic [NI-1:0] x);
    return {x[3] ^ x[1] ^ x[0], (x[2] & x[1]) | x[0]};
  endfunction

  // Scan wrapper: input chain, capture register and MSB-first output chain.
  always @(posedge clk) begin
    if (bus.shift_in_en) in_chain <= {in_chain[NI-2:0], bus.scan_in};
    if (bus.capture) out_chain <= cut_fn(in_chain);
    else if (bus.shift_out_en) out_chain <= {out_chain[NO-2:0], 1'b0};
  end

  assign bus.scan_out = out_chain[NO-1];
  assign bus.exp_resp = cut_fn(bus.pat_idx) ^ corrupt[bus.pat_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // A pattern fails exactly when its golden entry was corrupted.
  function automatic exp_t model(input int upto);
    exp_t e;
    e.fc = 0;
    e.ff = 0;
    e.start_cyc = 0;
    for (int p = 0; p < upto; p++) begin
      if (corrupt[p] != '0) begin
        if (e.fc == 0) e.ff = p;
        e.fc++;
      end
    end
    e.fany = (e.fc != 0) ? 1 : 0;
    return e;
  endfunction

  task automatic randomize_corrupt();
    for (int p = 0; p < NPAT; p++)
      corrupt[p] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  task automatic issue_start(output exp_t e);
    e = model(NPAT);
    @(negedge clk);
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_run(input bit poke);
    exp_t e;
    issue_start(e);
    for (int i = 0; i < 400; i++) begin
      if (!bus.busy) break;
      bus.start = poke && (i > 2) && (i < 110) && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("run_finished", {31'b0, bus.busy}, 0);
    repeat (3) @(negedge clk);
    chk("hold_fail_count", 32'(bus.fail_count), e.fc);
    chk("hold_first_fail", 32'(bus.first_fail), e.ff);
  endtask

  // Monitor: tracks serialization per pattern and scores each done pulse.
  initial begin
    exp_t e;
    logic [NI-1:0] coll;
    int sin_n, sout_n, exp_pat;
    logic pb, psin, psout, pdone;
    coll = '0; sin_n = 0; sout_n = 0; exp_pat = 0;
    pb = 1'b0; psin = 1'b0; psout = 1'b0; pdone = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        coll = '0; sin_n = 0; sout_n = 0; exp_pat = 0;
        pb = 1'b0; psin = 1'b0; psout = 1'b0; pdone = 1'b0;
        continue;
      end
      if (bus.busy && !pb) begin
        coll = '0; sin_n = 0; sout_n = 0; exp_pat = 0;
      end
      chk("en_exclusive",
          {31'b0, $countones({bus.shift_in_en, bus.capture, bus.shift_out_en}) <= 1}, 1);
      if (bus.shift_in_en) begin
        coll = {coll[NI-2:0], bus.scan_in};
        sin_n++;
      end
      if (bus.capture) begin
        chk("capture_follows_shift_in", {31'b0, psin}, 1);
        chk("scan_in_bits", 32'(coll), exp_pat);
        chk("shift_in_len", sin_n, NI);
        chk("pat_idx", 32'(bus.pat_idx), exp_pat);
        exp_pat++;
        sin_n = 0;
      end
      if (bus.shift_out_en) begin
        sout_n++;
      end else if (psout) begin
        chk("shift_out_len", sout_n, NO);
        sout_n = 0;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'b0, bus.done}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("fail_count", 32'(bus.fail_count), e.fc);
          chk("fail_any", {31'b0, bus.fail_any}, e.fany);
          chk("first_fail", 32'(bus.first_fail), e.ff);
          chk("run_length", cyc - e.start_cyc + 1, RUN_CYC);
          chk("busy_at_done", {31'b0, bus.busy}, 1);
          chk("patterns_applied", exp_pat, NPAT);
        end
      end
      if (pdone) begin
        chk("done_width", {31'b0, bus.done}, 0);
        chk("busy_after_done", {31'b0, bus.busy}, 0);
      end
      pb = bus.busy; psin = bus.shift_in_en; psout = bus.shift_out_en; pdone = bus.done;
    end
  end

  initial begin
    exp_t e;
    bit   found;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int p = 0; p < NPAT; p++) corrupt[p] = 2'b00;

    #1 rst = 1'b1;
    #3;
    chk("reset_ctrl", {26'b0, bus.scan_in, bus.shift_in_en, bus.capture, bus.shift_out_en,
                       bus.busy, bus.done}, 0);
    chk("reset_results", {18'b0, bus.pat_idx, bus.fail_count, bus.fail_any, bus.first_fail}, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // start and abort together in idle: abort wins.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", {31'b0, bus.busy}, 0);

    do_run(1'b0);

    corrupt[5] = 2'($urandom_range(1, 3));
    do_run(1'b1);

    for (int p = 0; p < NPAT; p++) corrupt[p] = 2'b11;
    do_run(1'b0);

    // Abort sampled on the 40th edge after start: lands in pattern 4, whose compare is dropped.
    randomize_corrupt();
    corrupt[4] = 2'b00;
    e = model(4);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_pat_idx", 32'(bus.pat_idx), 4);
    chk("abort_partial_count", 32'(bus.fail_count), e.fc);
    chk("abort_partial_first", 32'(bus.first_fail), e.ff);
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", {31'b0, bus.busy}, 0);

    // Asynchronous reset in the middle of a shift-out phase.
    randomize_corrupt();
    issue_start(e);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.shift_out_en) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_shift_out", {31'b0, found}, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_ctrl", {26'b0, bus.scan_in, bus.shift_in_en, bus.capture, bus.shift_out_en,
                            bus.busy, bus.done}, 0);
    chk("midrun_rst_results",
        {18'b0, bus.pat_idx, bus.fail_count, bus.fail_any, bus.first_fail}, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    #1 rst = 1'b0;
    do_run(1'b0);

    for (int r = 0; r < 3; r++) begin
      randomize_corrupt();
      do_run(1'b1);
    end

    repeat (5) @(negedge clk);
    chk("runs_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
